// File: rtl/phys_reg_file_rdy_pkg.sv
// Shared core parameters and types for the physical register file.
//   NUM_PREGS : physical register count (power of two, >= 4)
//   NUM_FUS   : functional units; sets default read/writeback pipe counts
//   XLEN      : data width
//   preg_t    : physical register index type
package phys_reg_file_rdy_pkg;

  localparam int NUM_PREGS = 64;
  localparam int NUM_FUS   = 2;
  localparam int XLEN      = 32;
  localparam int PW        = $clog2(NUM_PREGS);

  typedef logic [PW-1:0] preg_t;

endpackage

// File: rtl/phys_reg_file_rdy_if.sv
// Bundle of read, writeback, allocation and status signals between the
// pipeline (master) and the physical register file (slave).
//   rd_src1/2_preg -> operand indices    rd_src1/2_val/rdy <- operand data/ready
//   wr_valid/preg/val -> writebacks      alloc_valid/preg  -> rename allocations
//   flush -> mark all ready              busy_cnt, wr_conflict <- status
interface phys_reg_file_rdy_if #(
  parameter int NUM_PREGS    = 64,
  parameter int XLEN         = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_WR_PORTS = 2,
  parameter int NUM_ALLOC    = 2
);
  localparam int PW = $clog2(NUM_PREGS);
  localparam int CW = $clog2(NUM_PREGS + 1);

  logic [NUM_RD_PORTS-1:0][PW-1:0]   rd_src1_preg;
  logic [NUM_RD_PORTS-1:0][PW-1:0]   rd_src2_preg;
  logic [NUM_RD_PORTS-1:0][XLEN-1:0] rd_src1_val;
  logic [NUM_RD_PORTS-1:0][XLEN-1:0] rd_src2_val;
  logic [NUM_RD_PORTS-1:0]           rd_src1_rdy;
  logic [NUM_RD_PORTS-1:0]           rd_src2_rdy;
  logic [NUM_WR_PORTS-1:0]           wr_valid;
  logic [NUM_WR_PORTS-1:0][PW-1:0]   wr_preg;
  logic [NUM_WR_PORTS-1:0][XLEN-1:0] wr_val;
  logic [NUM_ALLOC-1:0]              alloc_valid;
  logic [NUM_ALLOC-1:0][PW-1:0]      alloc_preg;
  logic                              flush;
  logic [CW-1:0]                     busy_cnt;
  logic                              wr_conflict;

  modport master (
    output rd_src1_preg, rd_src2_preg, wr_valid, wr_preg, wr_val,
           alloc_valid, alloc_preg, flush,
    input  rd_src1_val, rd_src2_val, rd_src1_rdy, rd_src2_rdy,
           busy_cnt, wr_conflict
  );

  modport slave (
    input  rd_src1_preg, rd_src2_preg, wr_valid, wr_preg, wr_val,
           alloc_valid, alloc_preg, flush,
    output rd_src1_val, rd_src2_val, rd_src1_rdy, rd_src2_rdy,
           busy_cnt, wr_conflict
  );
endinterface

// File: rtl/phys_reg_file_rdy_ready_table.sv
// Ready-bit scoreboard: one ready bit per preg, alloc/write/flush priority,
// registered busy counter and ready queries with optional write bypass.
//   wr_valid/wr_preg       : writebacks set ready
//   alloc_valid/alloc_preg : allocations clear ready (wins over a write)
//   flush                  : sets every ready bit, drops same-cycle allocs
//   query_preg/query_rdy   : combinational readiness lookups
//   busy_cnt               : count of not-ready pregs
module prf_ready_table #(
  parameter int NUM_PREGS    = 64,
  parameter int NUM_WR_PORTS = 2,
  parameter int NUM_ALLOC    = 2,
  parameter int NUM_QUERY    = 4,
  parameter int BYPASS       = 1,
  localparam int PW          = $clog2(NUM_PREGS),
  localparam int CW          = $clog2(NUM_PREGS + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_WR_PORTS-1:0]        wr_valid,
  input  logic [NUM_WR_PORTS-1:0][PW-1:0] wr_preg,
  input  logic [NUM_ALLOC-1:0]           alloc_valid,
  input  logic [NUM_ALLOC-1:0][PW-1:0]   alloc_preg,
  input  logic                           flush,
  input  logic [NUM_QUERY-1:0][PW-1:0]   query_preg,
  output logic [NUM_QUERY-1:0]           query_rdy,
  output logic [CW-1:0]                  busy_cnt
);

  logic [NUM_PREGS-1:0] ready_q, ready_d;
  logic [CW-1:0]        busy_cnt_q, busy_cnt_d;

  always_comb begin
    // NOTE: every comb output gets a default first so no latch is inferred.
    ready_d = ready_q;
    for (int p = 0; p < NUM_WR_PORTS; p++)
      if (wr_valid[p]) ready_d[wr_preg[p]] = 1'b1;
    // Applied after writes so an alloc clear beats a same-cycle write set.
    if (flush) ready_d = '1;
    else
      for (int a = 0; a < NUM_ALLOC; a++)
        if (alloc_valid[a]) ready_d[alloc_preg[a]] = 1'b0;
    ready_d[0] = 1'b1;

    // Counted from the next-state vector so busy_cnt matches next-cycle rdy.
    busy_cnt_d = '0;
    for (int i = 0; i < NUM_PREGS; i++)
      busy_cnt_d = busy_cnt_d + CW'(!ready_d[i]);
  end

  always_comb begin
    query_rdy = '0;
    for (int q = 0; q < NUM_QUERY; q++) begin
      query_rdy[q] = ready_q[query_preg[q]] || (query_preg[q] == '0);
      if (BYPASS != 0)
        for (int p = 0; p < NUM_WR_PORTS; p++)
          if (wr_valid[p] && wr_preg[p] == query_preg[q]) query_rdy[q] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q    <= '1;
      busy_cnt_q <= '0;
    end else begin
      ready_q    <= ready_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

endmodule

// File: rtl/phys_reg_file_rdy.sv
// Multi-port physical register file with ready scoreboard, same-cycle
// write-to-read bypass, busy counter and sticky write-conflict flag.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of phys_reg_file_rdy_if (reads, writebacks,
//              allocations, flush, busy_cnt, wr_conflict)
module phys_reg_file_rdy
  import phys_reg_file_rdy_pkg::*;
#(
  parameter int NUM_PREGS    = phys_reg_file_rdy_pkg::NUM_PREGS,
  parameter int XLEN         = phys_reg_file_rdy_pkg::XLEN,
  parameter int NUM_RD_PORTS = NUM_FUS,
  parameter int NUM_WR_PORTS = NUM_FUS,
  parameter int NUM_ALLOC    = 2,
  parameter int BYPASS       = 1
) (
  input logic               clk,
  input logic               rst,
  phys_reg_file_rdy_if.slave bus
);

  localparam int PW = $clog2(NUM_PREGS);

  logic [XLEN-1:0] mem_q [NUM_PREGS];
  logic [XLEN-1:0] mem_d [NUM_PREGS];
  logic            wr_conflict_q, wr_conflict_d;
  logic            conflict;

  logic [2*NUM_RD_PORTS-1:0][PW-1:0] query_preg;
  logic [2*NUM_RD_PORTS-1:0]         query_rdy;

  // Ascending port order: the highest-numbered matching port wins.
  always_comb begin
    mem_d = mem_q;
    for (int p = 0; p < NUM_WR_PORTS; p++)
      if (bus.wr_valid[p] && bus.wr_preg[p] != '0)
        mem_d[bus.wr_preg[p]] = bus.wr_val[p];
  end

  always_comb begin
    conflict = 1'b0;
    for (int p = 0; p < NUM_WR_PORTS; p++)
      for (int q = p + 1; q < NUM_WR_PORTS; q++)
        if (bus.wr_valid[p] && bus.wr_valid[q] &&
            bus.wr_preg[p] == bus.wr_preg[q] && bus.wr_preg[p] != '0)
          conflict = 1'b1;
    wr_conflict_d = wr_conflict_q | conflict;
  end

  always_comb begin
    bus.rd_src1_val = '0;
    bus.rd_src2_val = '0;
    for (int r = 0; r < NUM_RD_PORTS; r++) begin
      bus.rd_src1_val[r] = mem_q[bus.rd_src1_preg[r]];
      bus.rd_src2_val[r] = mem_q[bus.rd_src2_preg[r]];
      if (BYPASS != 0)
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
          if (bus.wr_valid[p] && bus.wr_preg[p] == bus.rd_src1_preg[r])
            bus.rd_src1_val[r] = bus.wr_val[p];
          if (bus.wr_valid[p] && bus.wr_preg[p] == bus.rd_src2_preg[r])
            bus.rd_src2_val[r] = bus.wr_val[p];
        end
      // preg 0 is hard-wired zero, even against a bypassed write.
      if (bus.rd_src1_preg[r] == '0) bus.rd_src1_val[r] = '0;
      if (bus.rd_src2_preg[r] == '0) bus.rd_src2_val[r] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data array is reset on purpose: pregs must read 0 after rst.
      for (int i = 0; i < NUM_PREGS; i++) mem_q[i] <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign bus.wr_conflict = wr_conflict_q;

  // Low half of the query vector serves src1, high half serves src2.
  assign query_preg      = {bus.rd_src2_preg, bus.rd_src1_preg};
  assign bus.rd_src1_rdy = query_rdy[NUM_RD_PORTS-1:0];
  assign bus.rd_src2_rdy = query_rdy[2*NUM_RD_PORTS-1:NUM_RD_PORTS];

  prf_ready_table #(
    .NUM_PREGS   (NUM_PREGS),
    .NUM_WR_PORTS(NUM_WR_PORTS),
    .NUM_ALLOC   (NUM_ALLOC),
    .NUM_QUERY   (2 * NUM_RD_PORTS),
    .BYPASS      (BYPASS)
  ) u_ready_table (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (bus.wr_valid),
    .wr_preg    (bus.wr_preg),
    .alloc_valid(bus.alloc_valid),
    .alloc_preg (bus.alloc_preg),
    .flush      (bus.flush),
    .query_preg (query_preg),
    .query_rdy  (query_rdy),
    .busy_cnt   (bus.busy_cnt)
  );

endmodule

// File: doc/phys_reg_file_rdy.md
# phys_reg_file_rdy

Parametrised multi-port physical register file with an integrated ready-bit scoreboard, same-cycle write-to-read bypass and a busy-register counter. It sits between rename/dispatch, which allocates destination pregs, the issue/reg-read stage, which reads operands and queries readiness, and the execute writeback ports. It generalises the single-pipe register file to NUM_RD_PORTS read pipes and NUM_WR_PORTS writeback pipes, and adds wakeup state.

## Interface
Parameters:
- NUM_PREGS, 64: physical registers. Power of two, ≥ 4.
- XLEN, 32: data width.
- NUM_RD_PORTS, NUM_FUS: read pipes. Each pipe has two source operands.
- NUM_WR_PORTS, NUM_FUS: writeback ports.
- NUM_ALLOC, 2: rename allocation ports per cycle.
- BYPASS, 1: 1 forwards same-cycle writes to reads and ready queries; 0 disables forwarding.

Ports (PW = $clog2(NUM_PREGS), CW = $clog2(NUM_PREGS+1)):
- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_src1_preg, rd_src2_preg  in  NUM_RD_PORTS×PW  operand indices per pipe.
- rd_src1_val, rd_src2_val  out  NUM_RD_PORTS×XLEN  operand data.
- rd_src1_rdy, rd_src2_rdy  out  NUM_RD_PORTS×1  operand ready.
- wr_valid  in  NUM_WR_PORTS×1  writeback valid.
- wr_preg  in  NUM_WR_PORTS×PW  writeback destination.
- wr_val  in  NUM_WR_PORTS×XLEN  writeback data.
- alloc_valid  in  NUM_ALLOC×1  destination allocated by rename.
- alloc_preg  in  NUM_ALLOC×PW  allocated index.
- flush  in  1  recovery: mark all pregs ready.
- busy_cnt  out  CW  number of not-ready pregs.
- wr_conflict  out  1  sticky error flag.

## Operation
- Storage: NUM_PREGS×XLEN data array plus a NUM_PREGS ready vector.
- preg 0 reads as 0 and is always ready. Writes and allocs to it are ignored.
- Reads are combinational, with 0-cycle latency.
  - BYPASS=1: if a write port has wr_valid=1 with wr_preg equal to the read index in the same cycle, the output is that port's wr_val. Otherwise the output is the array value.
  - BYPASS=0: the output is always the array value.
- Ready queries follow the same rule: a same-cycle matching write forces rdy=1 when BYPASS=1.
- Write: on the rising edge, array[wr_preg] ← wr_val and ready[wr_preg] ← 1 for each valid port.
- Alloc: on the rising edge, ready[alloc_preg] ← 0. The data array is unchanged.
- Priority per preg, per edge, highest first:
  1. rst
  2. flush (all ready bits set to 1; a same-cycle alloc is dropped)
  3. alloc (clear wins over a same-cycle write's set; the data is still written)
  4. write
- Two or more valid write ports to the same non-zero preg in one cycle: the highest-numbered port wins for data and bypass, and wr_conflict is set to 1. wr_conflict stays set until rst.
- busy_cnt equals the population count of ~ready. It is registered and updated every edge from the next-state ready vector, so it is always consistent with rdy queries in the following cycle.

## Timing
- Reset values while rst=1 at an edge:
  - all data = 0
  - all ready = 1
  - busy_cnt = 0
  - wr_conflict = 0
  - wr_valid, alloc_valid and flush are ignored.
- Outputs during and after reset:
  - rd_*_val show the array, so they read 0 from the edge after the rst edge.
  - rd_*_rdy read 1 from that same point.
- Read latency: same cycle, combinational. Without bypass, a written value is visible from the cycle after the write edge.
- Alloc in cycle N: rdy reads 0 from cycle N+1; busy_cnt increments at the edge ending cycle N.
- Alloc in cycle N followed by a write in cycle M > N: rdy reads 1 in cycle M with BYPASS=1, in M+1 without; busy_cnt decrements at the edge ending M.
- Reset asserted mid-operation: all pending writes and allocs in that cycle are discarded.

## Structure
- CORE_PKG owns NUM_PREGS, NUM_FUS, XLEN and preg_t (logic [PW-1:0]).
- Sub-module prf_ready_table owns:
  - the ready vector
  - the alloc/write/flush priority
  - busy_cnt
  - ready-query bypass
- The data array, read muxing/bypass and conflict detection stay in the top.

## Test plan
- Reset, then query pregs 0, 7 and 63 → val 0, rdy 1, busy_cnt 0, wr_conflict 0.
- Write 12 to preg 7 on port 0 and 13 to preg 8 on port 1 in the same cycle; read both next cycle → 12 and 13.
- BYPASS=1: write 0xDEAD to preg 5 and read preg 5 in the same cycle → 0xDEAD. With BYPASS=0, the same stimulus → old value 0.
- Alloc pregs 9 and 10 → busy_cnt 2, rdy 0. Write preg 9 → rdy 1 same cycle (bypass), busy_cnt 1 next cycle. Flush → busy_cnt 0.
- Same-cycle alloc and write to preg 11 with value 77 → next cycle: rdy 0, val 77, busy_cnt +1.
- Ports 0 and 1 both write preg 4 with values 1 and 2 → val 2, wr_conflict 1 until rst. Write 99 to preg 0 → reads 0.
